// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: coin credit, price check, dispenser handshake, change return.
// Optional feature: define MULTI_VEND_EN to return to CREDIT after a vend with leftover credit.
module vend_sequencer #(
  parameter int PRICE0         = 25,
  parameter int PRICE1         = 50,
  parameter int PRICE2         = 75,
  parameter int PRICE3         = 100,
  parameter int MAX_CREDIT     = 200,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic       vend_req,
  output logic [1:0] vend_id,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic [7:0] credit,
  output logic       insufficient,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    MAX_SUM      = 9'(MAX_CREDIT);

  logic [1:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    credit_n, change_amount_n, price;
  logic [1:0]    vend_id_n;
  logic          vend_req_n, change_valid_n, insufficient_n, coin_reject_n, busy_n;
  logic          coin_live, enter_change;
  logic [8:0]    sum;

  always_comb begin
    case (sel_id)
      2'd0:    price = 8'(PRICE0);
      2'd1:    price = 8'(PRICE1);
      2'd2:    price = 8'(PRICE2);
      default: price = 8'(PRICE3);
    endcase
  end

  // NOTE: every signal assigned below gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n         = state;
    timer_n         = timer;
    credit_n        = credit;
    vend_req_n      = vend_req;
    vend_id_n       = vend_id;
    change_amount_n = change_amount;
    change_valid_n  = 1'b0;
    insufficient_n  = 1'b0;
    coin_reject_n   = 1'b0;
    enter_change    = 1'b0;
    coin_live       = coin_valid && (coin_value != 8'd0);
    sum             = {1'b0, credit} + {1'b0, coin_value};

    // A coin loses to any higher-priority strobe in the same cycle.
    if (coin_live && (cancel || sel_valid)) coin_reject_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (sel_valid && !cancel) begin
          insufficient_n = 1'b1;
        end else if (coin_live && !cancel) begin
          if ({1'b0, coin_value} <= MAX_SUM) begin
            credit_n = coin_value;
            timer_n  = '0;
            state_n  = S_CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          enter_change = 1'b1;
        end else if (sel_valid && (credit >= price)) begin
          credit_n   = credit - price;
          vend_req_n = 1'b1;
          vend_id_n  = sel_id;
          timer_n    = '0;
          state_n    = S_VEND;
        end else if (!sel_valid && coin_live && (sum <= MAX_SUM)) begin
          credit_n = sum[7:0];
          timer_n  = '0;
        end else begin
          if (sel_valid) insufficient_n = 1'b1;
          else if (coin_live) coin_reject_n = 1'b1;
          if (timer == TIMEOUT_LAST) enter_change = 1'b1;
          else timer_n = timer + 1'b1;
        end
      end
      S_VEND: begin
        if (coin_live) coin_reject_n = 1'b1;
        if (vend_ack) begin
          vend_req_n = 1'b0;
          if (credit == 8'd0) begin
            state_n = S_IDLE;
          end else begin
`ifdef MULTI_VEND_EN
            state_n = S_CREDIT;
            timer_n = '0;
`else
            enter_change = 1'b1;
`endif
          end
        end
      end
      default: begin
        if (coin_live) coin_reject_n = 1'b1;
        credit_n = 8'd0;
        state_n  = S_IDLE;
      end
    endcase

    // Nothing to refund means no change cycle at all.
    if (enter_change) begin
      if (credit_n == 8'd0) begin
        state_n = S_IDLE;
      end else begin
        state_n         = S_CHANGE;
        change_valid_n  = 1'b1;
        change_amount_n = credit_n;
      end
    end

    busy_n = (state_n == S_VEND) || (state_n == S_CHANGE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      credit        <= 8'd0;
      vend_req      <= 1'b0;
      vend_id       <= 2'd0;
      change_valid  <= 1'b0;
      change_amount <= 8'd0;
      insufficient  <= 1'b0;
      coin_reject   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      credit        <= credit_n;
      vend_req      <= vend_req_n;
      vend_id       <= vend_id_n;
      change_valid  <= change_valid_n;
      change_amount <= change_amount_n;
      insufficient  <= insufficient_n;
      coin_reject   <= coin_reject_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction sequencer for the vending machine. It accumulates inserted coins into a credit register and checks product selections against a fixed price table. It drives a request/acknowledge handshake to the product dispenser and returns residual credit as change. It sits between the coin/keypad front end and the dispenser/change-return hardware, and replaces the single-shot money handling with an explicit per-transaction state machine.

## Interface
Parameters:
- PRICE0, 25: price of product 0 (8-bit)
- PRICE1, 50: price of product 1
- PRICE2, 75: price of product 2
- PRICE3, 100: price of product 3
- MAX_CREDIT, 200: credit ceiling, must be ≤ 255
- TIMEOUT_CYCLES, 1000: idle cycles in CREDIT before auto-refund, must be ≥ 1

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- coin_valid  in  1  one-cycle strobe, coin present
- coin_value  in  8  coin value in ₹, sampled with coin_valid; 0 is ignored
- sel_valid  in  1  one-cycle strobe, product selected
- sel_id  in  2  product index, sampled with sel_valid
- cancel  in  1  one-cycle strobe, refund request
- vend_ack  in  1  dispenser done, sampled only while vend_req=1
- vend_req  out  1  dispense request, level, held until acknowledged
- vend_id  out  2  product being dispensed, stable while vend_req=1
- change_valid  out  1  one-cycle pulse, change_amount valid
- change_amount  out  8  refund value in ₹
- credit  out  8  current credit, registered
- insufficient  out  1  one-cycle pulse, selection refused
- coin_reject  out  1  one-cycle pulse, coin returned
- busy  out  1  high in VEND or CHANGE

## Operation
- States: IDLE, CREDIT, VEND, CHANGE.
- All outputs are registered. Reset value of every output is 0. On reset, state goes to IDLE and credit and the timeout counter clear.
- Reset during VEND drops vend_req on the next edge. Credit is discarded and no change pulse is issued.
- Event priority in one cycle, highest first: cancel, then sel_valid, then coin_valid.
  - A coin arriving with a higher-priority event is rejected with coin_reject.
  - A selection arriving with cancel is ignored.
- IDLE:
  - A valid coin sets credit=coin_value and moves to CREDIT.
  - sel_valid produces an insufficient pulse.
  - cancel is ignored.
- CREDIT:
  - Coin: compute a 9-bit sum credit+coin_value. If the sum is ≤ MAX_CREDIT, credit takes the sum. Otherwise coin_reject pulses and credit is unchanged.
  - Selection: if credit ≥ PRICE[sel_id], credit -= price, vend_id=sel_id, vend_req=1, and the state moves to VEND. Otherwise insufficient pulses, credit is kept, and the state stays CREDIT.
  - cancel moves to CHANGE.
  - Timeout counter clears on any accepted coin or selection and increments otherwise. At the count TIMEOUT_CYCLES the state moves to CHANGE.
- VEND:
  - vend_req is held until vend_ack=1.
  - Coins are rejected with coin_reject; selections and cancel are ignored.
  - On ack, vend_req clears and the next state depends on credit and on MULTI_VEND_EN (see Configuration).
- CHANGE:
  - Emits one change_valid pulse with change_amount=credit.
  - Clears credit and moves to IDLE.
  - Coins are rejected.
- Zero-credit rule: any transition that would enter CHANGE with credit=0 goes straight to IDLE with no change pulse.

## Timing
- Strobes sampled at edge N produce a response at edge N+1: vend_req rise, insufficient, coin_reject, credit update.
- vend_ack sampled at edge N gives vend_req=0 at edge N+1. An ack asserted in the same cycle vend_req rises is honoured. The minimum VEND dwell is 1 cycle.
- CHANGE lasts exactly 1 cycle. change_valid and change_amount are valid for that one cycle, and credit reads 0 on the following cycle.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted event in CREDIT.
- Back-to-back strobes on consecutive cycles are each handled independently.

## Configuration
- MULTI_VEND_EN defined:
  - After vend_ack with credit > 0, return to CREDIT (buy-more).
  - The timeout counter is cleared on this return.
  - If credit = 0, go to IDLE.
- MULTI_VEND_EN undefined:
  - After vend_ack with credit > 0, go to CHANGE and refund immediately.
  - If credit = 0, go to IDLE.

## Test plan
- Exact payment: coin 25, sel 0 → vend_req=1 with vend_id=0. Ack → vend_req=0, no change pulse, IDLE, credit=0.
- Insufficient: coin 25, sel 1 → insufficient pulse, no vend_req, credit stays 25.
- Change (macro off): coin 100, sel 2, ack → change_valid with change_amount=25, then IDLE.
- Overflow and cancel: coins 100, 100, 10 → third coin gets coin_reject and credit=200. Cancel → change 200.
- Timeout: coin 10, then no activity for TIMEOUT_CYCLES → change_valid with 10 at the exact cycle. Also check that a coin during VEND is rejected.
- Buy-more (MULTI_VEND_EN): coin 100, sel 1, ack → credit=50 in CREDIT. Sel 1, ack → credit=0, IDLE, no change pulse.
